data_mem_mmio: RTL and testbench
================================

Name: data_mem_mmio

Overview:
Data-memory stage directly downstream of the single-cycle datapath. It consumes the datapath's ALUResult (address), WriteData and MemWrite, and returns ReadData in the same cycle. Low addresses map to a word RAM. A memory-mapped I/O window above IO_BASE holds:
- an LED register
- a synchronized switch input
- a free-running cycle counter
- a 4-entry TX FIFO with a valid/ready handshake toward a serial peripheral

Parameters:
RAM_WORDS, 64, number of 32-bit RAM words; power of two.
IO_BASE, 32'h0000_1000, first byte address of the MMIO window.
FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2.
LED_W, 10, width of LED and switch fields.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
MemWrite  in  1  store strobe from the control unit.
Addr  in  32  byte address (datapath ALUResult).
WriteData  in  32  store data.
ReadData  out  32  load data, combinational from Addr.
sw_in  in  LED_W  asynchronous board switches.
led_out  out  LED_W  LED register contents.
tx_data  out  8  FIFO head byte.
tx_valid  out  1  FIFO non-empty.
tx_ready  in  1  peripheral accepts the head byte this cycle.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - led_out, FIFO pointers and count, overflow flag, cycle counter and both switch-sync flops → 0
  - tx_valid=0 immediately
  - RAM contents are not cleared.
- Decode uses Addr[1:0] ignored, so accesses are word aligned.
  - Addr < IO_BASE and word index < RAM_WORDS: RAM.
  - Addr < IO_BASE and index ≥ RAM_WORDS: reads return 0; writes are dropped.
  - Addr ≥ IO_BASE: MMIO at offset Addr-IO_BASE.
- RAM:
  - Asynchronous read.
  - Write at the clk edge when MemWrite=1.
  - A read of the same address in the write cycle returns the old value.
- MMIO map (offsets):
  - 0x00 LED: reads/writes bits [LED_W-1:0]; upper bits read 0.
  - 0x04 SW: read-only; returns the 2-flop-synchronized sw_in, so there is 2-cycle latency from a pin change; writes are ignored.
  - 0x08 TXDATA: a write pushes WriteData[7:0]. If the FIFO is full and no pop happens the same cycle, the byte is dropped and sticky overflow is set. Reads return 0.
  - 0x0C STATUS: read {26'b0, count[2:0], overflow, empty, full} as bits [5:3], [2], [1], [0]; count is zero-extended when FIFO_DEPTH<8. A write with WriteData[2]=1 clears overflow. Set and clear in the same cycle: set wins.
  - 0x10 CYCLES: the counter increments by 1 every cycle and wraps 0xFFFF_FFFF→0. A write loads WriteData, and the load wins over the increment. A read returns the current registered value.
  - Any other offset reads 0; writes to it are ignored.
- TX FIFO:
  - tx_valid = !empty; tx_data = head entry.
  - A pop occurs when tx_valid && tx_ready.
  - Push and pop in the same cycle:
    - When non-empty: both happen and count is unchanged.
    - When full: both happen, and the push is accepted.
    - When empty: only the push happens; the new byte appears on tx_data the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
- MemWrite=0 has no side effects: reads never pop or clear anything.

Decomposition:
- Package mem_map_pkg holds:
  - IO_BASE default and offsets OFF_LED=0x00, OFF_SW=0x04, OFF_TX=0x08, OFF_STAT=0x0C, OFF_CYC=0x10
  - STATUS bit indices ST_FULL=0, ST_EMPTY=1, ST_OVF=2, ST_CNT_LSB=3
  - a region_t enum {REG_RAM, REG_NONE, REG_IO}
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), exposes push/pop/full/empty/count.
- Decode, the RAM, the registers and the synchronizer stay in the top level.

Test Plan:
- RAM round trip: write 0xDEADBEEF to 0x20, then read 0x20 → 0xDEADBEEF. Read 0x21 → the same word. Read 0x400 (index 256 ≥ 64) → 0.
- LED and reset: write 0x3FF to IO_BASE+0x00 → led_out=0x3FF and readback 0x000003FF. Drop reset to 0 mid-cycle → led_out=0 immediately.
- Switch sync: sw_in 0→0x155 at cycle N → a read of IO_BASE+0x04 returns 0 in cycle N and N+1, and 0x155 from cycle N+2.
- FIFO fill and overflow, with tx_ready=0:
  - Push 0x11, 0x22, 0x33, 0x44 → STATUS=0x21 (count=4, full).
  - Push 0x55 → dropped, STATUS=0x25.
  - Write STATUS with 0x4 → 0x21.
  - Raise tx_ready → tx_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then tx_valid=0 and STATUS=0x02.
- Simultaneous push and pop when full: with the FIFO full and tx_ready=1, push 0x66 → count stays 4, no overflow, and 0x66 is the last byte out.
- Counter: 10 cycles after reset release, read CYCLES → 10. Write 0xFFFFFFFE → reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000 on successive cycles.

Source files
------------

// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - address map, STATUS bit layout and decode region type for data_mem_mmio
package mem_map_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0000_1000;

  localparam logic [31:0] OFF_LED  = 32'h0000_0000;
  localparam logic [31:0] OFF_SW   = 32'h0000_0004;
  localparam logic [31:0] OFF_TX   = 32'h0000_0008;
  localparam logic [31:0] OFF_STAT = 32'h0000_000C;
  localparam logic [31:0] OFF_CYC  = 32'h0000_0010;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 3;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_NONE,
    REG_IO
  } region_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push into a full FIFO is taken only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/data_mem_mmio.sv
// rtl/data_mem_mmio.sv - data memory stage: word RAM below IO_BASE, LED/switch/TX/status/cycle registers above
module data_mem_mmio
  import mem_map_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT,
  parameter int          FIFO_DEPTH = 4,
  parameter int          LED_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  input  logic [LED_W-1:0] sw_in,
  output logic [LED_W-1:0] led_out,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  region_t           region;
  logic [31:0]       io_word;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_led, wr_tx, wr_stat, wr_cyc;
  logic [31:0]       ram_q [RAM_WORDS];
  logic [31:0]       ram_d [RAM_WORDS];
  logic [LED_W-1:0]  led_q, led_d;
  logic [LED_W-1:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [31:0]       cyc_q, cyc_d;
  logic              ovf_q, ovf_d;
  logic              fifo_full, fifo_empty, tx_pop;
  logic [FIFO_AW:0]  fifo_count;
  logic [31:0]       status;

  always_comb begin
    io_word = (Addr - IO_BASE) & ~32'h3;
    ram_idx = Addr[RAM_AW+1:2];
    if (Addr >= IO_BASE) begin
      region = REG_IO;
    end else if ({2'b00, Addr[31:2]} < 32'(RAM_WORDS)) begin
      region = REG_RAM;
    end else begin
      region = REG_NONE;
    end
  end

  assign wr_led  = MemWrite && (region == REG_IO) && (io_word == OFF_LED);
  assign wr_tx   = MemWrite && (region == REG_IO) && (io_word == OFF_TX);
  assign wr_stat = MemWrite && (region == REG_IO) && (io_word == OFF_STAT);
  assign wr_cyc  = MemWrite && (region == REG_IO) && (io_word == OFF_CYC);

  assign tx_valid = !fifo_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign led_out  = led_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (wr_tx),
    .push_data (WriteData[7:0]),
    .pop       (tx_pop),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    status                  = '0;
    status[ST_FULL]         = fifo_full;
    status[ST_EMPTY]        = fifo_empty;
    status[ST_OVF]          = ovf_q;
    status[ST_CNT_LSB +: 3] = 3'(fifo_count);
  end

  always_comb begin
    ram_d = ram_q;
    if (MemWrite && (region == REG_RAM)) begin
      ram_d[ram_idx] = WriteData;
    end
    led_d     = wr_led ? WriteData[LED_W-1:0] : led_q;
    sw_meta_d = sw_in;
    sw_sync_d = sw_meta_q;
    cyc_d     = wr_cyc ? WriteData : cyc_q + 32'd1;
    // Clear first so a drop in the same cycle leaves the flag set.
    ovf_d = ovf_q;
    if (wr_stat && WriteData[ST_OVF]) begin
      ovf_d = 1'b0;
    end
    if (wr_tx && fifo_full && !tx_pop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    ReadData = '0;
    case (region)
      REG_RAM: ReadData = ram_q[ram_idx];
      REG_IO: begin
        case (io_word)
          OFF_LED:  ReadData = 32'(led_q);
          OFF_SW:   ReadData = 32'(sw_sync_q);
          OFF_STAT: ReadData = status;
          OFF_CYC:  ReadData = cyc_q;
          default:  ReadData = '0;
        endcase
      end
      default: ReadData = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    ram_q <= ram_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cyc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      cyc_q     <= cyc_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb/tb_data_mem_mmio.sv - scoreboard bench for data_mem_mmio with a behavioural memory/MMIO model
module tb_data_mem_mmio;

  localparam logic [31:0] IO_BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [9:0]  sw_in;
  logic [9:0]  led_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  data_mem_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] ram_m [64];
  logic [9:0]  led_m, sw_h1, sw_h2;
  logic [31:0] cyc_m;
  int          fifo_cnt;
  bit          ovf_m;

  logic [31:0] rd_exp_q [$];
  string       nm_q [$];
  logic [7:0]  tx_exp_q [$];
  bit          chk_rd, exp_valid, mon_en;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    led_m    = '0;
    sw_h1    = '0;
    sw_h2    = '0;
    cyc_m    = '0;
    fifo_cnt = 0;
    ovf_m    = 1'b0;
    tx_exp_q.delete();
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    if (a < IO_BASE) return ((a >> 2) < 64) ? ram_m[a[7:2]] : 32'h0;
    off = (a - IO_BASE) & ~32'h3;
    case (off)
      32'h00:  return {22'h0, led_m};
      32'h04:  return {22'h0, sw_h2};
      32'h0C:  return {26'h0, 3'(fifo_cnt), ovf_m, fifo_cnt == 0, fifo_cnt == 4};
      32'h10:  return cyc_m;
      default: return 32'h0;
    endcase
  endfunction

  // mode 0: no read check, 1: expect model value, 2: expect the literal given
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic rdy, input int mode, input logic [31:0] lit, input string nm);
    logic [31:0] off;
    bit          io;
    MemWrite  = we;
    Addr      = a;
    WriteData = wd;
    tx_ready  = rdy;
    exp_valid = (fifo_cnt != 0);
    if (mode != 0) begin
      rd_exp_q.push_back(mode == 2 ? lit : model_read(a));
      nm_q.push_back(nm);
    end
    chk_rd = (mode != 0);
    @(posedge clk);
    io  = (a >= IO_BASE);
    off = (a - IO_BASE) & ~32'h3;
    if (fifo_cnt != 0 && rdy) fifo_cnt--;
    if (we && io && off == 32'h0C && wd[2]) ovf_m = 1'b0;
    if (we && io && off == 32'h08) begin
      if (fifo_cnt < 4) begin
        fifo_cnt++;
        tx_exp_q.push_back(wd[7:0]);
      end else begin
        ovf_m = 1'b1;
      end
    end
    cyc_m = (we && io && off == 32'h10) ? wd : cyc_m + 32'd1;
    if (we && io && off == 32'h00) led_m = wd[9:0];
    if (we && !io && (a >> 2) < 64) ram_m[a[7:2]] = wd;
    sw_h2 = sw_h1;
    sw_h1 = sw_in;
    #1;
  endtask

  task automatic mid_reset();
    MemWrite = 1'b0;
    mon_en   = 1'b0;
    chk_rd   = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("rst_led_out", 32'(led_out), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("tx_valid", 32'(tx_valid), 32'(exp_valid));
      check("led_out", 32'(led_out), 32'(led_m));
      if (tx_valid && tx_exp_q.size() > 0) begin
        check("tx_data", 32'(tx_data), 32'(tx_exp_q[0]));
        if (tx_ready) void'(tx_exp_q.pop_front());
      end
      if (chk_rd && rd_exp_q.size() > 0) begin
        check(nm_q.pop_front(), ReadData, rd_exp_q.pop_front());
      end
    end
  end

  localparam logic [31:0] A_LED  = IO_BASE + 32'h00;
  localparam logic [31:0] A_SW   = IO_BASE + 32'h04;
  localparam logic [31:0] A_TX   = IO_BASE + 32'h08;
  localparam logic [31:0] A_STAT = IO_BASE + 32'h0C;
  localparam logic [31:0] A_CYC  = IO_BASE + 32'h10;

  initial begin
    logic [31:0] offs [8];
    logic [31:0] a;
    offs = '{32'h00, 32'h04, 32'h08, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h40};
    mon_en = 1'b0; chk_rd = 1'b0; exp_valid = 1'b0;
    reset = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0; tx_ready = 1'b0; sw_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    repeat (10) step(1'b0, IO_BASE + 32'h40, 32'h0, 1'b0, 0, 32'h0, "");
    step(1'b0, A_CYC, 32'h0, 1'b0, 2, 32'd10, "cycles_after_reset");
    step(1'b1, A_CYC, 32'hFFFF_FFFE, 1'b0, 1, 32'h0, "cycles_pre_load");
    step(1'b0, A_CYC, 32'h0, 1'b0, 2, 32'hFFFF_FFFE, "cycles_load");
    step(1'b0, A_CYC, 32'h0, 1'b0, 2, 32'hFFFF_FFFF, "cycles_max");
    step(1'b0, A_CYC, 32'h0, 1'b0, 2, 32'h0000_0000, "cycles_wrap");

    for (int i = 0; i < 64; i++) step(1'b1, 32'(i) * 4, $urandom, 1'b0, 0, 32'h0, "");
    step(1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0, 0, 32'h0, "");
    step(1'b0, 32'h20, 32'h0, 1'b0, 2, 32'hDEAD_BEEF, "ram_0x20");
    step(1'b0, 32'h21, 32'h0, 1'b0, 2, 32'hDEAD_BEEF, "ram_0x21");
    step(1'b0, 32'h400, 32'h0, 1'b0, 2, 32'h0, "ram_oob_read");
    step(1'b1, 32'h20, 32'h1234_5678, 1'b0, 2, 32'hDEAD_BEEF, "ram_read_during_write");
    step(1'b0, 32'h20, 32'h0, 1'b0, 2, 32'h1234_5678, "ram_after_write");

    step(1'b1, A_LED, 32'hFFFF_F3FF, 1'b0, 0, 32'h0, "");
    step(1'b0, A_LED, 32'h0, 1'b0, 2, 32'h0000_03FF, "led_readback");

    sw_in = '0;
    repeat (2) step(1'b0, A_SW, 32'h0, 1'b0, 0, 32'h0, "");
    sw_in = 10'h155;
    step(1'b0, A_SW, 32'h0, 1'b0, 2, 32'h0, "sw_cycle_n");
    step(1'b0, A_SW, 32'h0, 1'b0, 2, 32'h0, "sw_cycle_n1");
    step(1'b0, A_SW, 32'h0, 1'b0, 2, 32'h155, "sw_cycle_n2");

    step(1'b1, A_TX, 32'h11, 1'b0, 2, 32'h0, "txdata_read");
    step(1'b1, A_TX, 32'h22, 1'b0, 0, 32'h0, "");
    step(1'b1, A_TX, 32'h33, 1'b0, 0, 32'h0, "");
    step(1'b1, A_TX, 32'h44, 1'b0, 0, 32'h0, "");
    step(1'b0, A_STAT, 32'h0, 1'b0, 2, 32'h21, "status_full");
    step(1'b1, A_TX, 32'h55, 1'b0, 0, 32'h0, "");
    step(1'b0, A_STAT, 32'h0, 1'b0, 2, 32'h25, "status_overflow");
    step(1'b1, A_STAT, 32'h4, 1'b0, 0, 32'h0, "");
    step(1'b0, A_STAT, 32'h0, 1'b0, 2, 32'h21, "status_ovf_cleared");
    repeat (4) step(1'b0, A_STAT, 32'h0, 1'b1, 0, 32'h0, "");
    step(1'b0, A_STAT, 32'h0, 1'b0, 2, 32'h02, "status_drained");

    for (int i = 0; i < 4; i++) step(1'b1, A_TX, 32'h61 + 32'(i), 1'b0, 0, 32'h0, "");
    step(1'b1, A_TX, 32'h66, 1'b1, 0, 32'h0, "");
    step(1'b0, A_STAT, 32'h0, 1'b0, 2, 32'h21, "status_push_pop_full");
    repeat (4) step(1'b0, A_STAT, 32'h0, 1'b1, 0, 32'h0, "");
    step(1'b0, A_STAT, 32'h0, 1'b0, 2, 32'h02, "status_after_66");

    step(1'b1, A_LED, 32'h3FF, 1'b0, 0, 32'h0, "");
    step(1'b1, A_TX, 32'h77, 1'b0, 0, 32'h0, "");
    mid_reset();
    step(1'b0, A_STAT, 32'h0, 1'b0, 2, 32'h02, "status_after_reset");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) a = 32'($urandom_range(0, 79)) * 4 + 32'($urandom_range(0, 3));
      else a = IO_BASE + offs[$urandom_range(0, 7)] + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) sw_in = 10'($urandom_range(0, 1023));
      step(1'($urandom_range(0, 1)), a, $urandom,
           1'($urandom_range(0, 99) < ((i % 200) < 100 ? 30 : 80)), 1, 32'h0, "rand_read");
    end

    for (int i = 0; i < 8 && fifo_cnt != 0; i++) step(1'b0, A_STAT, 32'h0, 1'b1, 0, 32'h0, "");
    step(1'b0, A_STAT, 32'h0, 1'b0, 1, 32'h0, "final_status");
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
